// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN datapath blocks: arbiter state encoding,
// default sizing and a constant-width helper.
package cnn_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_t;

  localparam int P_DEFAULT  = 4;
  localparam int AW_DEFAULT = 10;
  localparam int BW_DEFAULT = 4;

  // Ceiling log2, never below 1 so that index vectors always have a bit.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: rotate the request vector so that the
// pointer position sits at bit 0, take the lowest set bit, rotate back.
module rr_picker
  import cnn_pkg::*;
#(
  parameter int P  = P_DEFAULT,
  parameter int PW = clog2(P)
) (
  input  logic [P-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [PW-1:0] win,
  output logic          any
);

  logic [2*P-1:0] doubled;
  logic [P-1:0]   rotated;

  assign doubled = {req, req};
  assign rotated = doubled[int'(ptr) +: P];

  // Priority-encode the rotated vector and map the offset back to an index.
  always_comb begin
    int off;
    int sum;
    off = 0;
    for (int k = P - 1; k >= 0; k--) begin
      if (rotated[k]) off = k;
    end
    sum = int'(ptr) + off;
    if (sum >= P) sum = sum - P;
    win = PW'(sum);
    any = |req;
  end

endmodule

// File: rtl/ifm_mem_arbiter.sv
// Round-robin arbiter for the shared IFM memory read port. One burst is
// served at a time; a mandatory IDLE cycle separates consecutive bursts.
module ifm_mem_arbiter
  import cnn_pkg::*;
#(
  parameter int P  = P_DEFAULT,
  parameter int AW = AW_DEFAULT,
  parameter int BW = BW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [P-1:0]  req,
  input  logic [P*AW-1:0] req_addr,
  input  logic [P*BW-1:0] req_len,
  output logic [P-1:0]  gnt,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  output logic [P-1:0]  rvalid,
  output logic          rlast,
  output logic          busy
);

  localparam int PW = clog2(P);

  arb_state_t    state_q;
  logic [PW-1:0] ptr_q;
  logic [PW-1:0] win_q;
  logic [AW-1:0] base_q;
  logic [BW-1:0] len_m1_q;
  logic [BW-1:0] beat_q;
  logic [P-1:0]  rvalid_q;
  logic          rlast_q;

  logic [PW-1:0] pick_win;
  logic          pick_any;
  logic [AW-1:0] pick_addr;
  logic [BW-1:0] pick_len;
  logic [P-1:0]  win_onehot;
  logic          last_beat;
  logic          in_burst;

  rr_picker #(
    .P  (P),
    .PW (PW)
  ) u_picker (
    .req (req),
    .ptr (ptr_q),
    .win (pick_win),
    .any (pick_any)
  );

  assign pick_addr  = req_addr[int'(pick_win)*AW +: AW];
  assign pick_len   = req_len[int'(pick_win)*BW +: BW];
  assign win_onehot = P'(1) << win_q;
  assign last_beat  = (beat_q == len_m1_q);
  assign in_burst   = (state_q == ARB_BURST);

  // Port-side outputs decode registered state only; req never reaches them.
  assign busy     = in_burst;
  assign mem_rd   = in_burst;
  assign mem_addr = in_burst ? base_q + AW'(beat_q) : '0;
  assign gnt      = (in_burst && beat_q == '0) ? win_onehot : '0;
  assign rvalid   = rvalid_q;
  assign rlast    = rlast_q;

  // Arbitration FSM, burst address counter and the one-cycle read-return pipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ARB_IDLE;
      ptr_q    <= '0;
      win_q    <= '0;
      base_q   <= '0;
      len_m1_q <= '0;
      beat_q   <= '0;
      rvalid_q <= '0;
      rlast_q  <= 1'b0;
    end else begin
      rvalid_q <= in_burst ? win_onehot : '0;
      rlast_q  <= in_burst && last_beat;
      case (state_q)
        ARB_IDLE: begin
          if (pick_any) begin
            win_q    <= pick_win;
            base_q   <= pick_addr;
            len_m1_q <= (pick_len == '0) ? '0 : pick_len - BW'(1);
            beat_q   <= '0;
            state_q  <= ARB_BURST;
          end
        end
        ARB_BURST: begin
          if (last_beat) begin
            ptr_q   <= (win_q == PW'(P - 1)) ? '0 : win_q + PW'(1);
            state_q <= ARB_IDLE;
          end else begin
            beat_q <= beat_q + BW'(1);
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ifm_mem_arbiter.sv
// Self-checking bench for ifm_mem_arbiter: expected beats are queued when
// requests are driven and compared as the memory port and read return fire.
module tb_ifm_mem_arbiter;

  localparam int P  = 4;
  localparam int AW = 10;
  localparam int BW = 4;

  typedef struct {
    int           who;
    logic [AW-1:0] addr;
    bit           first;
    bit           last;
  } beat_t;

  logic            clk = 1'b0;
  logic            rst;
  logic [P-1:0]    req;
  logic [P*AW-1:0] req_addr;
  logic [P*BW-1:0] req_len;
  logic [P-1:0]    gnt;
  logic            mem_rd;
  logic [AW-1:0]   mem_addr;
  logic [P-1:0]    rvalid;
  logic            rlast;
  logic            busy;

  beat_t mem_q[$];
  beat_t rv_q[$];
  logic [P-1:0] cont;
  logic [P-1:0] last_gnt;
  int n_cmp = 0;
  int n_err = 0;

  ifm_mem_arbiter #(.P(P), .AW(AW), .BW(BW)) dut (
    .clk      (clk),
    .rst      (rst),
    .req      (req),
    .req_addr (req_addr),
    .req_len  (req_len),
    .gnt      (gnt),
    .mem_rd   (mem_rd),
    .mem_addr (mem_addr),
    .rvalid   (rvalid),
    .rlast    (rlast),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic set_req(input int i, input logic [AW-1:0] addr, input logic [BW-1:0] len);
    req_addr[i*AW +: AW] = addr;
    req_len[i*BW +: BW]  = len;
    req[i] = 1'b1;
  endtask

  task automatic push_burst(input int who, input logic [AW-1:0] addr, input int len);
    int n;
    beat_t e;
    n = (len == 0) ? 1 : len;
    for (int b = 0; b < n; b++) begin
      e.who   = who;
      e.addr  = AW'(int'(addr) + b);
      e.first = (b == 0);
      e.last  = (b == n - 1);
      mem_q.push_back(e);
      rv_q.push_back(e);
    end
  endtask

  // One clock cycle: requester drop rule after the edge, scoreboard at negedge.
  task automatic step();
    beat_t e;
    logic [P-1:0] oh;
    @(posedge clk);
    #1;
    req = req & ~(last_gnt & ~cont);
    @(negedge clk);
    last_gnt = gnt;
    if (!rst) begin
      if (mem_rd) begin
        n_cmp++;
        if (mem_q.size() == 0) begin
          n_err++;
          $display("FAIL mem_beat: unexpected read addr=%0d gnt=%b, required no read", mem_addr, gnt);
        end else begin
          e  = mem_q.pop_front();
          oh = e.first ? (P'(1) << e.who) : '0;
          if (mem_addr !== e.addr || gnt !== oh || busy !== 1'b1) begin
            n_err++;
            $display("FAIL mem_beat: addr=%0d gnt=%b busy=%b, required addr=%0d gnt=%b busy=1",
                     mem_addr, gnt, busy, e.addr, oh);
          end
        end
      end else begin
        n_cmp++;
        if (gnt !== '0 || busy !== 1'b0) begin
          n_err++;
          $display("FAIL idle_port: gnt=%b busy=%b, required gnt=0 busy=0", gnt, busy);
        end
      end
      if (rvalid !== '0) begin
        n_cmp++;
        if (rv_q.size() == 0) begin
          n_err++;
          $display("FAIL read_return: unexpected rvalid=%b, required none", rvalid);
        end else begin
          e  = rv_q.pop_front();
          oh = P'(1) << e.who;
          if (rvalid !== oh || rlast !== e.last) begin
            n_err++;
            $display("FAIL read_return: rvalid=%b rlast=%b, required rvalid=%b rlast=%b",
                     rvalid, rlast, oh, e.last);
          end
        end
      end else begin
        n_cmp++;
        if (rlast !== 1'b0) begin
          n_err++;
          $display("FAIL rlast_alone: rlast=%b without rvalid, required 0", rlast);
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    cont = '0;
    step();
    step();
    rst = 1'b0;
    last_gnt = '0;
    mem_q.delete();
    rv_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    req_addr = '0;
    req_len = '0;
    cont = '0;
    last_gnt = '0;
    for (int i = 0; i < 3; i++) step();
    n_cmp++;
    if ({gnt, mem_rd, mem_addr, rvalid, rlast, busy} !== '0) begin
      n_err++;
      $display("FAIL reset_outputs: gnt=%b mem_rd=%b addr=%0d rvalid=%b rlast=%b busy=%b, required all 0",
               gnt, mem_rd, mem_addr, rvalid, rlast, busy);
    end
    rst = 1'b0;
    last_gnt = '0;
  endtask

  task automatic test_single();
    set_req(1, 10'd5, 4'd3);
    push_burst(1, 10'd5, 3);
    step();
    n_cmp++;
    if (mem_rd !== 1'b1 || gnt !== 4'b0010 || rvalid !== '0) begin
      n_err++;
      $display("FAIL single_latency: mem_rd=%b gnt=%b rvalid=%b, required 1 0010 0000", mem_rd, gnt, rvalid);
    end
    step();
    n_cmp++;
    if (rvalid !== 4'b0010) begin
      n_err++;
      $display("FAIL single_rvalid_latency: rvalid=%b, required 0010", rvalid);
    end
    for (int i = 0; i < 6; i++) step();
    n_cmp++;
    if (busy !== 1'b0 || mem_q.size() != 0 || rv_q.size() != 0) begin
      n_err++;
      $display("FAIL single_done: busy=%b pending_mem=%0d pending_rv=%0d, required 0 0 0",
               busy, mem_q.size(), rv_q.size());
    end
  endtask

  task automatic test_two_simultaneous();
    logic [7:0] pattern;
    do_reset();
    pattern = 8'b0011_1011;  // bit n = expected mem_rd in cycle n+1
    set_req(0, 10'd100, 4'd2);
    set_req(2, 10'd200, 4'd3);
    push_burst(0, 10'd100, 2);
    push_burst(2, 10'd200, 3);
    for (int n = 0; n < 8; n++) begin
      step();
      n_cmp++;
      if (mem_rd !== pattern[n]) begin
        n_err++;
        $display("FAIL two_sim_gap: cycle %0d mem_rd=%b, required %b", n + 1, mem_rd, pattern[n]);
      end
    end
    // Pointer should now sit at 3: a full request set must start with 3.
    for (int i = 0; i < P; i++) set_req(i, AW'(600 + i), 4'd1);
    push_burst(3, 10'd603, 1);
    push_burst(0, 10'd600, 1);
    push_burst(1, 10'd601, 1);
    push_burst(2, 10'd602, 1);
    for (int i = 0; i < 12; i++) step();
    n_cmp++;
    if (mem_q.size() != 0 || rv_q.size() != 0 || req !== '0) begin
      n_err++;
      $display("FAIL two_sim_done: pending_mem=%0d pending_rv=%0d req=%b, required 0 0 0000",
               mem_q.size(), rv_q.size(), req);
    end
  endtask

  task automatic test_fairness();
    do_reset();
    cont = '1;
    for (int i = 0; i < P; i++) set_req(i, AW'(40 + i), 4'd1);
    for (int k = 0; k < 16; k++) push_burst(k % P, AW'(40 + (k % P)), 1);
    for (int n = 1; n <= 31; n++) begin
      step();
      n_cmp++;
      if (mem_rd !== n[0]) begin
        n_err++;
        $display("FAIL fair_gap: cycle %0d mem_rd=%b, required %b", n, mem_rd, n[0]);
      end
      if (n == 31) begin
        req  = '0;
        cont = '0;
      end
    end
    for (int i = 0; i < 4; i++) step();
    n_cmp++;
    if (mem_q.size() != 0 || rv_q.size() != 0) begin
      n_err++;
      $display("FAIL fair_done: pending_mem=%0d pending_rv=%0d, required 0 0", mem_q.size(), rv_q.size());
    end
  endtask

  task automatic test_wrap_zero();
    int reads;
    set_req(3, 10'd1022, 4'd4);
    push_burst(3, 10'd1022, 4);
    reads = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (mem_rd === 1'b1) reads++;
    end
    n_cmp++;
    if (reads != 4) begin
      n_err++;
      $display("FAIL wrap_beats: %0d reads, required 4", reads);
    end
    set_req(3, 10'd77, 4'd0);
    push_burst(3, 10'd77, 0);
    reads = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (mem_rd === 1'b1) reads++;
    end
    n_cmp++;
    if (reads != 1 || mem_q.size() != 0 || rv_q.size() != 0) begin
      n_err++;
      $display("FAIL zero_len: %0d reads pending_rv=%0d, required 1 read 0 pending", reads, rv_q.size());
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    // A short burst by requester 2 leaves the pointer at 3.
    set_req(2, 10'd10, 4'd1);
    push_burst(2, 10'd10, 1);
    for (int i = 0; i < 4; i++) step();
    set_req(2, 10'd300, 4'd8);
    push_burst(2, 10'd300, 8);
    step();
    step();
    step();
    n_cmp++;
    if (mem_addr !== 10'd302) begin
      n_err++;
      $display("FAIL midreset_beat2: addr=%0d, required 302", mem_addr);
    end
    rst = 1'b1;
    step();
    n_cmp++;
    if ({gnt, mem_rd, mem_addr, rvalid, rlast, busy} !== '0) begin
      n_err++;
      $display("FAIL midreset_outputs: gnt=%b mem_rd=%b addr=%0d rvalid=%b rlast=%b busy=%b, required all 0",
               gnt, mem_rd, mem_addr, rvalid, rlast, busy);
    end
    mem_q.delete();
    rv_q.delete();
    rst = 1'b0;
    req = '0;
    last_gnt = '0;
    // With the pointer back at 0, requester 2 must beat requester 3.
    set_req(2, 10'd400, 4'd2);
    set_req(3, 10'd500, 4'd1);
    push_burst(2, 10'd400, 2);
    push_burst(3, 10'd500, 1);
    step();
    n_cmp++;
    if (gnt !== 4'b0100) begin
      n_err++;
      $display("FAIL midreset_ptr: gnt=%b, required 0100", gnt);
    end
    for (int i = 0; i < 9; i++) step();
    n_cmp++;
    if (mem_q.size() != 0 || rv_q.size() != 0) begin
      n_err++;
      $display("FAIL midreset_done: pending_mem=%0d pending_rv=%0d, required 0 0", mem_q.size(), rv_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_two_simultaneous();
    test_fairness();
    test_wrap_zero();
    test_reset_mid_burst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
